glyph_frame_sequencer: RTL

Frame-level controller for the glyph-mode VGA pipeline. Synchronises the asynchronous mode and palette pins into the clock domain and owns the animation frame counter and drop-reset flag. Applies palette changes only at frame boundaries. Changes video mode by holding the timing generator in reset for a fixed window starting at a frame boundary. Sits between the pin inputs and the timing generator / palette ROM, and replaces the vsync-clocked frame logic with a single-clock design.

---
 rtl/glyph_frame_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/glyph_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : glyph_frame_sequencer
// Purpose  : Frame-level controller: pin synchronisers, frame counter, palette
//            and mode application at frame boundaries for the glyph VGA path.
// Revision : 1.0 - initial release
// ============================================================================
module glyph_frame_sequencer #(
    parameter int FRAME_W     = 10,
    parameter int HOLD_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode_req_i,
    input  logic [1:0]         pal_req_i,
    input  logic               frame_start_i,
    output logic [1:0]         mode_o,
    output logic [1:0]         pal_o,
    output logic               gen_reset_o,
    output logic [FRAME_W-1:0] frame_o,
    output logic               rst_drop_o,
    output logic               busy_o,
    output logic               mode_changed_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [SYNC_STAGES-1:0][1:0] mode_sync_q;
    logic [SYNC_STAGES-1:0][1:0] pal_sync_q;
    logic [1:0]                  mode_s;
    logic [1:0]                  pal_s;

    logic [1:0]         state_q,     state_d;
    logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
    logic [1:0]         mode_q,      mode_d;
    logic [1:0]         pal_q,       pal_d;
    logic               gen_reset_q, gen_reset_d;
    logic [FRAME_W-1:0] frame_q,     frame_d;
    logic               rst_drop_q,  rst_drop_d;
    logic               changed_q,   changed_d;
    logic               mode_diff;

    assign mode_s    = mode_sync_q[SYNC_STAGES-1];
    assign pal_s     = pal_sync_q[SYNC_STAGES-1];
    assign mode_diff = (mode_s != mode_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync_q <= '0;
            pal_sync_q  <= '0;
            state_q     <= ST_RUN;
            hold_cnt_q  <= '0;
            mode_q      <= '0;
            pal_q       <= '0;
            gen_reset_q <= 1'b0;
            frame_q     <= '0;
            rst_drop_q  <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], mode_req_i};
            pal_sync_q  <= {pal_sync_q[SYNC_STAGES-2:0], pal_req_i};
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            mode_q      <= mode_d;
            pal_q       <= pal_d;
            gen_reset_q <= gen_reset_d;
            frame_q     <= frame_d;
            rst_drop_q  <= rst_drop_d;
            changed_q   <= changed_d;
        end
    end

    // A cancel in PEND wins over a coincident frame_start: nothing to switch to.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (mode_diff) state_d = ST_PEND;
            ST_PEND: begin
                if (!mode_diff)         state_d = ST_RUN;
                else if (frame_start_i) state_d = ST_HOLD;
            end
            ST_HOLD: if (hold_cnt_q == '0) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        mode_d      = mode_q;
        pal_d       = pal_q;
        gen_reset_d = gen_reset_q;
        frame_d     = frame_q;
        rst_drop_d  = rst_drop_q;
        changed_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (frame_start_i) begin
                    pal_d   = pal_s;
                    frame_d = frame_q + FRAME_W'(1);
                    if (&frame_q) rst_drop_d = 1'b1;
                end
            end
            ST_PEND: begin
                if (mode_diff && frame_start_i) begin
                    mode_d      = mode_s;
                    pal_d       = pal_s;
                    gen_reset_d = 1'b1;
                    frame_d     = '0;
                    rst_drop_d  = 1'b0;
                    hold_cnt_d  = HOLD_LAST;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    gen_reset_d = 1'b0;
                    changed_d   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign mode_o         = mode_q;
    assign pal_o          = pal_q;
    assign gen_reset_o    = gen_reset_q;
    assign frame_o        = frame_q;
    assign rst_drop_o     = rst_drop_q;
    assign busy_o         = (state_q != ST_RUN);
    assign mode_changed_o = changed_q;

endmodule
`default_nettype wire
